// File: rtl/exec_sequencer.sv
// ============================================================================
//  Module      : exec_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit
//                processor. Owns the PC, strobes the IR latch, data-memory
//                request and register-file write. One instruction in flight.
//  Config      : `define EXEC_SEQ_PERF_COUNT_EN to enable the saturating
//                retired-instruction counter (otherwise instr_count = 0).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_sequencer #(
    parameter int PC_W        = 10,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            jump_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] target,
    input  logic            is_mem,
    input  logic            is_halt,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            mem_req,
    output logic            reg_we,
    output logic            running,
    output logic            done,
    output logic            err,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Wait counter value seen in the last permitted MEM cycle (counter is 0
    // in the first MEM cycle).
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_next_pc;
    logic [7:0]      r_wait;
    logic            w_start_accept;
    logic            w_timeout;

    assign w_start_accept = start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_timeout      = (r_state == S_MEM) && !mem_ready && (r_wait == c_WAIT_LAST);

    // Next-state selection from the current state and the sampled inputs
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_next_state = S_FETCH;
            S_FETCH:        w_next_state = S_DECODE;
            S_DECODE:       w_next_state = is_halt ? S_HALT : S_EXEC;
            S_EXEC:         w_next_state = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready)      w_next_state = S_WB;
                else if (w_timeout) w_next_state = S_HALT;
            end
            S_WB:           w_next_state = S_FETCH;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // State, PC, error flag and Moore strobes registered from the next state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            pc        <= '0;
            r_next_pc <= '0;
            r_wait    <= '0;
            err       <= 1'b0;
            ir_load   <= 1'b0;
            mem_req   <= 1'b0;
            reg_we    <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            ir_load <= (w_next_state == S_FETCH);
            mem_req <= (w_next_state == S_MEM);
            reg_we  <= (w_next_state == S_WB);
            running <= (w_next_state != S_IDLE) && (w_next_state != S_HALT);
            done    <= (w_next_state == S_HALT);

            // Counter is zero on MEM entry because it idles at zero elsewhere
            r_wait <= (r_state == S_MEM) ? r_wait + 8'd1 : 8'd0;

            if (w_start_accept) begin
                pc  <= start_addr;
                err <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_next_pc <= (jump_en || branch_en) ? target : pc + PC_W'(1);
            end
            if (r_state == S_WB) begin
                pc <= r_next_pc;
            end
            if (w_timeout) begin
                err <= 1'b1;
            end
        end
    end

`ifdef EXEC_SEQ_PERF_COUNT_EN
    logic [15:0] r_instr_count;

    // Saturating count of instructions retired through WB
    always_ff @(posedge CLK) begin
        if (Reset || w_start_accept) begin
            r_instr_count <= 16'h0000;
        end else if ((r_state == S_WB) && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none

module tb_exec_sequencer;

    localparam int PC_W        = 10;
    localparam int MEM_TIMEOUT = 15;

    logic            CLK = 1'b0;
    logic            Reset;
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            jump_en;
    logic            branch_en;
    logic [PC_W-1:0] target;
    logic            is_mem;
    logic            is_halt;
    logic            mem_ready;
    logic [PC_W-1:0] pc;
    logic            ir_load;
    logic            mem_req;
    logic            reg_we;
    logic            running;
    logic            done;
    logic            err;
    logic [15:0]     instr_count;

    exec_sequencer #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .start       (start),
        .start_addr  (start_addr),
        .jump_en     (jump_en),
        .branch_en   (branch_en),
        .target      (target),
        .is_mem      (is_mem),
        .is_halt     (is_halt),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .ir_load     (ir_load),
        .mem_req     (mem_req),
        .reg_we      (reg_we),
        .running     (running),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: architectural state at instruction granularity
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_fail   = 0;
    logic [PC_W-1:0] exp_pc;
    logic            exp_err;
    logic [15:0]     exp_cnt;
    bit              halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Compare every output against the model for the current cycle
    task automatic check_cycle(input string tag, input bit e_ir, input bit e_mr,
                               input bit e_we, input bit e_run, input bit e_dn);
        chk({tag, ":strobes"}, {26'd0, ir_load, mem_req, reg_we, running, done, err},
            {26'd0, e_ir, e_mr, e_we, e_run, e_dn, exp_err});
        chk({tag, ":pc"}, {22'd0, pc}, {22'd0, exp_pc});
`ifdef EXEC_SEQ_PERF_COUNT_EN
        chk({tag, ":count"}, {16'd0, instr_count}, {16'd0, exp_cnt});
`else
        chk({tag, ":count"}, {16'd0, instr_count}, 32'd0);
`endif
    endtask

    // Randomise inputs that the current state must ignore
    task automatic scramble();
        start      = 1'($urandom);
        start_addr = PC_W'($urandom);
        jump_en    = 1'($urandom);
        branch_en  = 1'($urandom);
        target     = PC_W'($urandom);
        is_mem     = 1'($urandom);
        is_halt    = 1'($urandom);
        mem_ready  = 1'($urandom);
    endtask

    // Called at a negedge while idle or halted; leaves the DUT in FETCH
    task automatic do_start(input logic [PC_W-1:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start   = 1'b0;
        exp_pc  = addr;
        exp_err = 1'b0;
        exp_cnt = 16'h0000;
        halted  = 1'b0;
    endtask

    // Runs one instruction starting at the FETCH negedge. delay = MEM cycle in
    // which mem_ready is given (0 = never).
    task automatic exec_instr(input bit h, input bit j, input bit b,
                              input logic [PC_W-1:0] t, input bit m, input int delay);
        logic [PC_W-1:0] nxt;
        check_cycle("fetch", 1, 0, 0, 1, 0);
        scramble();
        tick();
        check_cycle("decode", 0, 0, 0, 1, 0);
        scramble();
        is_halt = h;
        tick();
        if (h) begin
            check_cycle("halt", 0, 0, 0, 0, 1);
            start  = 1'b0;
            halted = 1'b1;
            return;
        end
        check_cycle("exec", 0, 0, 0, 1, 0);
        scramble();
        jump_en   = j;
        branch_en = b;
        target    = t;
        is_mem    = m;
        nxt = (j || b) ? t : exp_pc + PC_W'(1);
        tick();
        if (m) begin
            for (int k = 1; k <= MEM_TIMEOUT; k++) begin
                check_cycle("mem", 0, 1, 0, 1, 0);
                scramble();
                mem_ready = (k == delay);
                tick();
                if (k == delay) break;
                if (k == MEM_TIMEOUT) begin
                    exp_err = 1'b1;
                    check_cycle("timeout", 0, 0, 0, 0, 1);
                    start  = 1'b0;
                    halted = 1'b1;
                    return;
                end
            end
        end
        check_cycle("wb", 0, 0, 1, 1, 0);
        scramble();
        tick();
        exp_pc = nxt;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        jump_en    = 1'b0;
        branch_en  = 1'b0;
        target     = '0;
        is_mem     = 1'b0;
        is_halt    = 1'b0;
        mem_ready  = 1'b0;
        exp_pc     = '0;
        exp_err    = 1'b0;
        exp_cnt    = 16'h0000;
        halted     = 1'b1;
        tick();
        tick();
        check_cycle("reset", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        tick();
        check_cycle("idle", 0, 0, 0, 0, 0);

        // Sequential execution, then branch / jump+branch targets
        do_start(10'h004);
        exec_instr(0, 0, 0, 10'h000, 0, 0);
        exec_instr(0, 0, 1, 10'h020, 0, 0);
        exec_instr(0, 1, 1, 10'h030, 0, 0);
        exec_instr(0, 1, 0, 10'h123, 0, 0);

        // Memory instruction with 3 MEM cycles, then a timeout
        exec_instr(0, 0, 0, 10'h000, 1, 3);
        exec_instr(0, 0, 0, 10'h000, 1, 1);
        exec_instr(0, 0, 0, 10'h000, 1, 0);

        // Restart from HALT clears err; PC wrap; halt instruction
        do_start(10'h3FF);
        exec_instr(0, 0, 0, 10'h000, 0, 0);
        exec_instr(0, 0, 0, 10'h000, 1, MEM_TIMEOUT);
        exec_instr(1, 0, 0, 10'h000, 0, 0);
        tick();
        check_cycle("halt_hold", 0, 0, 0, 0, 1);

        // Reset while in MEM aborts the instruction
        do_start(10'h050);
        check_cycle("fetch", 1, 0, 0, 1, 0);
        tick();
        check_cycle("decode", 0, 0, 0, 1, 0);
        is_halt = 1'b0;
        tick();
        check_cycle("exec", 0, 0, 0, 1, 0);
        is_mem    = 1'b1;
        jump_en   = 1'b0;
        branch_en = 1'b0;
        tick();
        check_cycle("mem", 0, 1, 0, 1, 0);
        mem_ready = 1'b1;
        Reset     = 1'b1;
        tick();
        exp_pc  = '0;
        exp_err = 1'b0;
        exp_cnt = 16'h0000;
        check_cycle("rst_mem", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        start = 1'b0;
        tick();
        check_cycle("rst_idle", 0, 0, 0, 0, 0);
        halted = 1'b1;

        // Randomised instruction stream against the model
        for (int i = 0; i < 80; i++) begin
            bit              rh, rj, rb, rm;
            logic [PC_W-1:0] rt;
            int              rd;
            if (halted) do_start(PC_W'($urandom));
            rh = ($urandom_range(0, 11) == 0);
            rj = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 3) == 0);
            rt = PC_W'($urandom);
            rm = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            exec_instr(rh, rj, rb, rt, rm, rd);
        end
        if (!halted) check_cycle("final_fetch", 1, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
